// File: rtl/ctrl_pkg.sv
// Shared opcode values, IR field positions, FSM state encoding and watchdog sizing
// for the hardwired control unit.
package ctrl_pkg;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_MUL  = 5'b01000;
    localparam logic [4:0] OP_DIV  = 5'b01001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int WDOG_W = 6;
    // The counter holds completed WAIT cycles, so 62 marks the 63rd WAIT cycle.
    localparam logic [WDOG_W-1:0] WDOG_LAST = 6'd62;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_WAIT, S_T5, S_T6, S_HALT
    } state_e;

    typedef enum logic [1:0] {
        CLS_NOP, CLS_ALU, CLS_MULDIV, CLS_HALT
    } opclass_e;

endpackage

// File: rtl/ir_decode.sv
// Combinational IR field extraction and opcode classification.
module ir_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [4:0]  opcode_o,
    output logic [3:0]  ra_o,
    output logic [3:0]  rb_o,
    output logic [3:0]  rc_o,
    output opclass_e    opClass_o,
    output logic        isDiv_o
);

    logic unusedIrBits;

    assign opcode_o     = ir_i[OP_MSB:OP_LSB];
    assign ra_o         = ir_i[RA_MSB:RA_LSB];
    assign rb_o         = ir_i[RB_MSB:RB_LSB];
    assign rc_o         = ir_i[RC_MSB:RC_LSB];
    assign isDiv_o      = (opcode_o == OP_DIV);
    assign unusedIrBits = ^ir_i[RC_LSB-1:0];

    // Unrecognised opcodes fall into the NOP class.
    always_comb begin
        opClass_o = CLS_NOP;
        case (opcode_o)
            OP_ADD, OP_SUB, OP_AND, OP_OR: opClass_o = CLS_ALU;
            OP_MUL, OP_DIV:                opClass_o = CLS_MULDIV;
            OP_HALT:                       opClass_o = CLS_HALT;
            default:                       opClass_o = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired multi-cycle control unit: fetch/decode/execute sequencer with an
// MDU wait state guarded by a watchdog that halts the machine on timeout.
module control_unit
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [31:0] IR,
    input  logic        mdu_done,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Read,
    output logic        MUL,
    output logic        DIV,
    output logic        Rout,
    output logic        Rin,
    output logic [3:0]  Rsel,
    output logic [4:0]  alu_op,
    output logic        halted,
    output logic        err
);

    state_e              state_q, state_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                err_q, err_d;

    logic [4:0]  opcode;
    logic [3:0]  ra, rb, rc;
    opclass_e    opClass;
    logic        isDiv;

    ir_decode u_ir_decode (
        .ir_i      (IR),
        .opcode_o  (opcode),
        .ra_o      (ra),
        .rb_o      (rb),
        .rc_o      (rc),
        .opClass_o (opClass),
        .isDiv_o   (isDiv)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wdog_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

    always_comb begin
        state_d  = state_q;
        wdog_d   = wdog_q;
        err_d    = err_q;
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        Zin      = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        MUL      = 1'b0;
        DIV      = 1'b0;
        Rout     = 1'b0;
        Rin      = 1'b0;
        Rsel     = 4'd0;
        alu_op   = 5'd0;
        halted   = 1'b0;

        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                case (opClass)
                    CLS_NOP:  state_d = run ? S_T0 : S_IDLE;
                    CLS_HALT: state_d = S_HALT;
                    default: begin
                        Rout    = 1'b1;
                        Rsel    = rb;
                        Yin     = 1'b1;
                        state_d = S_T4;
                    end
                endcase
            end
            S_T4: begin
                Rout   = 1'b1;
                Rsel   = rc;
                Zin    = 1'b1;
                alu_op = opcode;
                if (opClass == CLS_MULDIV) begin
                    MUL     = !isDiv;
                    DIV     = isDiv;
                    wdog_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_T5;
                end
            end
            S_WAIT: begin
                Rout   = 1'b1;
                Rsel   = rc;
                alu_op = opcode;
                MUL    = !isDiv;
                DIV    = isDiv;
                if (mdu_done) begin
                    state_d = S_T5;
                end else if (wdog_q == WDOG_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wdog_d  = wdog_q + 6'd1;
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (opClass == CLS_MULDIV) begin
                    LOin    = 1'b1;
                    state_d = S_T6;
                end else begin
                    Rin     = 1'b1;
                    Rsel    = ra;
                    state_d = run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                state_d  = run ? S_T0 : S_IDLE;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

endmodule
